// File: rtl/weight_pack_buffer.sv
// weight_pack_buffer: packs a serial weight stream into LANES-wide rows of a
// DEPTH-row store and serves two independent registered read ports.
// Optional build macro WEIGHT_PACK_FWD_EN: a read that hits the row being
// written in the same cycle returns the post-write row instead of the old one.
module weight_pack_buffer #(
  parameter int DATA_W   = 16,
  parameter int LANES    = 8,
  parameter int DEPTH    = 80,
  parameter int B_OFFSET = 25
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic [3:0]                cfg_lanes,
  input  logic [15:0]               cfg_rows,
  input  logic [15:0]               cfg_base,
  input  logic                      abort,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               fill_row,
  output logic [3:0]                fill_lane,
  input  logic                      rd_en_a,
  input  logic [15:0]               rd_addr_a,
  output logic [LANES*DATA_W-1:0]   rd_data_a,
  input  logic                      rd_en_b,
  input  logic [15:0]               rd_addr_b,
  output logic [LANES*DATA_W-1:0]   rd_data_b
);

  localparam int ROW_W = LANES * DATA_W;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0]    LANES_C  = 4'(LANES);
  localparam logic [15:0]   DEPTH_C  = 16'(DEPTH);
  localparam logic [16:0]   DEPTH_X  = 17'(DEPTH);
  localparam logic [16:0]   B_OFF_X  = 17'(B_OFFSET);
  localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ROW_ONE  = AW'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Post-write image of a row: lane 0 starts a fresh row (other lanes zero),
  // any later lane is merged into the existing contents.
  function automatic logic [ROW_W-1:0] pack_lane(
    input logic [ROW_W-1:0]  old_row,
    input logic [3:0]        lane,
    input logic [DATA_W-1:0] data
  );
    logic [ROW_W-1:0] row;
    if (lane == 4'd0) begin
      row = '0;
      row[DATA_W-1:0] = data;
    end else begin
      row = old_row;
      row[lane*DATA_W +: DATA_W] = data;
    end
    return row;
  endfunction

  state_t            state_r;
  logic [3:0]        lanes_r;
  logic [15:0]       rows_r;
  logic [AW-1:0]     wr_row_r;
  logic [15:0]       fill_row_r;
  logic [3:0]        fill_lane_r;
  logic              in_ready_r;
  logic              busy_r;
  logic              done_r;
  logic [ROW_W-1:0]  rd_data_a_r;
  logic [ROW_W-1:0]  rd_data_b_r;
  logic [ROW_W-1:0]  mem_r [DEPTH];

  logic              accept_s;
  logic              wr_en_s;
  logic              last_lane_s;
  logic              last_row_s;
  logic [3:0]        lanes_norm_s;
  logic [15:0]       rows_norm_s;
  logic [AW-1:0]     base_row_s;
  logic [ROW_W-1:0]  wr_old_s;
  logic [ROW_W-1:0]  wr_row_data_s;
  logic [16:0]       rd_full_a_s;
  logic [16:0]       rd_full_b_s;
  logic [AW-1:0]     rd_idx_a_s;
  logic [AW-1:0]     rd_idx_b_s;
  logic [ROW_W-1:0]  rd_row_a_s;
  logic [ROW_W-1:0]  rd_row_b_s;

  // Beat handshake, counter end conditions and the row image to be written.
  always_comb begin
    accept_s      = in_valid && in_ready_r;
    wr_en_s       = accept_s && !abort;
    last_lane_s   = (fill_lane_r == (lanes_r - 4'd1));
    last_row_s    = (fill_row_r == (rows_r - 16'd1));
    wr_old_s      = mem_r[wr_row_r];
    wr_row_data_s = pack_lane(wr_old_s, fill_lane_r, in_data);
  end

  // Normalise the configuration inputs before they are latched.
  always_comb begin
    if (cfg_lanes == 4'd0) begin
      lanes_norm_s = 4'd1;
    end else if (cfg_lanes > LANES_C) begin
      lanes_norm_s = LANES_C;
    end else begin
      lanes_norm_s = cfg_lanes;
    end
    if (cfg_rows == 16'd0) begin
      rows_norm_s = 16'd1;
    end else begin
      rows_norm_s = cfg_rows;
    end
    base_row_s = AW'(cfg_base % DEPTH_C);
  end

  // Fill controller: state, configuration, counters and handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      lanes_r     <= 4'd1;
      rows_r      <= 16'd1;
      wr_row_r    <= '0;
      fill_row_r  <= 16'd0;
      fill_lane_r <= 4'd0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (abort) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
          end else if (cfg_start) begin
            state_r     <= ST_FILL;
            lanes_r     <= lanes_norm_s;
            rows_r      <= rows_norm_s;
            wr_row_r    <= base_row_s;
            fill_row_r  <= 16'd0;
            fill_lane_r <= 4'd0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b1;
          end else begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        ST_FILL: begin
          if (abort) begin
            // Rows already written stay in memory; no completion pulse.
            state_r     <= ST_IDLE;
            fill_row_r  <= 16'd0;
            fill_lane_r <= 4'd0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
          end else if (accept_s) begin
            if (last_lane_s) begin
              fill_lane_r <= 4'd0;
              if (last_row_s) begin
                state_r    <= ST_DONE;
                fill_row_r <= 16'd0;
                in_ready_r <= 1'b0;
                busy_r     <= 1'b0;
                done_r     <= 1'b1;
              end else begin
                fill_row_r <= fill_row_r + 16'd1;
                if (wr_row_r == LAST_ROW) begin
                  wr_row_r <= '0;
                end else begin
                  wr_row_r <= wr_row_r + ROW_ONE;
                end
              end
            end else begin
              fill_lane_r <= fill_lane_r + 4'd1;
            end
          end else begin
            state_r <= ST_FILL;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          fill_row_r  <= 16'd0;
          fill_lane_r <= 4'd0;
          in_ready_r  <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  // Row store write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_row_r] <= wr_row_data_s;
    end
  end

  // Read address decode: port B offset is added at 17 bits so it never wraps.
  always_comb begin
    rd_full_a_s = {1'b0, rd_addr_a};
    rd_full_b_s = {1'b0, rd_addr_b} + B_OFF_X;
    rd_idx_a_s  = rd_full_a_s[AW-1:0];
    rd_idx_b_s  = rd_full_b_s[AW-1:0];
    if (rd_full_a_s < DEPTH_X) begin
      rd_row_a_s = mem_r[rd_idx_a_s];
`ifdef WEIGHT_PACK_FWD_EN
      if (wr_en_s && (rd_idx_a_s == wr_row_r)) begin
        rd_row_a_s = wr_row_data_s;
      end else begin
        rd_row_a_s = mem_r[rd_idx_a_s];
      end
`endif
    end else begin
      rd_row_a_s = '0;
    end
    if (rd_full_b_s < DEPTH_X) begin
      rd_row_b_s = mem_r[rd_idx_b_s];
`ifdef WEIGHT_PACK_FWD_EN
      if (wr_en_s && (rd_idx_b_s == wr_row_r)) begin
        rd_row_b_s = wr_row_data_s;
      end else begin
        rd_row_b_s = mem_r[rd_idx_b_s];
      end
`endif
    end else begin
      rd_row_b_s = '0;
    end
  end

  // Registered read ports; data holds while the enable is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_a_r <= '0;
      rd_data_b_r <= '0;
    end else begin
      if (rd_en_a) begin
        rd_data_a_r <= rd_row_a_s;
      end
      if (rd_en_b) begin
        rd_data_b_r <= rd_row_b_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign fill_row  = fill_row_r;
  assign fill_lane = fill_lane_r;
  assign rd_data_a = rd_data_a_r;
  assign rd_data_b = rd_data_b_r;

endmodule

// File: tb/tb_weight_pack_buffer.sv
// Self-checking bench for weight_pack_buffer: scripted scenarios followed by
// randomized fills, all checked against a lane-level memory model.
module tb_weight_pack_buffer;

  localparam int DATA_W   = 16;
  localparam int LANES    = 8;
  localparam int DEPTH    = 80;
  localparam int B_OFFSET = 25;
  localparam int ROW_W    = LANES * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start;
  logic [3:0]        cfg_lanes;
  logic [15:0]       cfg_rows;
  logic [15:0]       cfg_base;
  logic              abort;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic [15:0]       fill_row;
  logic [3:0]        fill_lane;
  logic              rd_en_a;
  logic [15:0]       rd_addr_a;
  logic [ROW_W-1:0]  rd_data_a;
  logic              rd_en_b;
  logic [15:0]       rd_addr_b;
  logic [ROW_W-1:0]  rd_data_b;

  weight_pack_buffer #(
    .DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .B_OFFSET(B_OFFSET)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_lanes(cfg_lanes),
    .cfg_rows(cfg_rows), .cfg_base(cfg_base), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .busy(busy), .done(done), .fill_row(fill_row), .fill_lane(fill_lane),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: weights stored per row and lane, plus the active fill.
  logic [DATA_W-1:0] m_mem [DEPTH][LANES];
  int m_lanes, m_rows, m_base, m_count, m_total;

  task automatic check_eq(input string tag, input logic [ROW_W-1:0] got,
                          input logic [ROW_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] model_row(input int r);
    logic [ROW_W-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*DATA_W +: DATA_W] = m_mem[r][l];
    return v;
  endfunction

  task automatic model_accept(input logic [DATA_W-1:0] d);
    int row, lane;
    row  = (m_base + m_count / m_lanes) % DEPTH;
    lane = m_count % m_lanes;
    if (lane == 0) begin
      for (int l = 0; l < LANES; l++) m_mem[row][l] = '0;
    end
    m_mem[row][lane] = d;
    m_count++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill(input logic [3:0] l, input logic [15:0] r,
                            input logic [15:0] b);
    cfg_lanes = l; cfg_rows = r; cfg_base = b; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    m_lanes = (l == 0) ? 1 : ((l > LANES) ? LANES : int'(l));
    m_rows  = (r == 0) ? 1 : int'(r);
    m_base  = int'(b) % DEPTH;
    m_count = 0;
    m_total = m_lanes * m_rows;
    check_eq("start_busy", busy, 1);
    check_eq("start_ready", in_ready, 1);
    check_eq("start_done", done, 0);
    check_eq("start_lane", fill_lane, 0);
  endtask

  task automatic beat(input logic [DATA_W-1:0] d, input bit ab);
    check_eq("ready_before_beat", in_ready, 1);
    in_valid = 1'b1; in_data = d; abort = ab;
    step();
    in_valid = 1'b0; abort = 1'b0;
    if (ab) begin
      check_eq("abort_busy", busy, 0);
      check_eq("abort_ready", in_ready, 0);
      check_eq("abort_done", done, 0);
    end else begin
      model_accept(d);
      if (m_count == m_total) begin
        check_eq("final_done", done, 1);
        check_eq("final_ready", in_ready, 0);
        check_eq("final_busy", busy, 0);
        check_eq("final_row", fill_row, 0);
        check_eq("final_lane", fill_lane, 0);
      end else begin
        check_eq("beat_done", done, 0);
        check_eq("beat_busy", busy, 1);
        check_eq("beat_row", fill_row, m_count / m_lanes);
        check_eq("beat_lane", fill_lane, m_count % m_lanes);
      end
    end
  endtask

  task automatic gap();
    in_valid = 1'b0;
    step();
    check_eq("gap_row", fill_row, m_count / m_lanes);
    check_eq("gap_lane", fill_lane, m_count % m_lanes);
    check_eq("gap_busy", busy, 1);
    check_eq("gap_done", done, 0);
  endtask

  task automatic settle();
    step();
    check_eq("settle_done", done, 0);
    check_eq("settle_ready", in_ready, 0);
    check_eq("settle_busy", busy, 0);
  endtask

  task automatic rd_a(input logic [15:0] addr, input string tag);
    logic [ROW_W-1:0] exp;
    rd_en_a = 1'b1; rd_addr_a = addr;
    step();
    rd_en_a = 1'b0;
    exp = (int'(addr) < DEPTH) ? model_row(int'(addr)) : '0;
    check_eq(tag, rd_data_a, exp);
  endtask

  task automatic rd_b(input logic [15:0] addr, input string tag);
    logic [ROW_W-1:0] exp;
    int row;
    rd_en_b = 1'b1; rd_addr_b = addr;
    step();
    rd_en_b = 1'b0;
    row = int'(addr) + B_OFFSET;
    exp = (row < DEPTH) ? model_row(row) : '0;
    check_eq(tag, rd_data_b, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ROW_W-1:0] pre_row, post_row, exp_row;
    int ab_at, row;
    bit chained;

    // Reset with stimulus active: everything must stay quiet.
    rst = 1'b0; cfg_start = 1'b0; cfg_lanes = 4'd0; cfg_rows = 16'd0;
    cfg_base = 16'd0; abort = 1'b0; in_valid = 1'b1; in_data = 16'h5A5A;
    rd_en_a = 1'b1; rd_addr_a = 16'd0; rd_en_b = 1'b1; rd_addr_b = 16'd0;
    repeat (3) step();
    check_eq("rst_ready", in_ready, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_row", fill_row, 0);
    check_eq("rst_lane", fill_lane, 0);
    check_eq("rst_rda", rd_data_a, 0);
    check_eq("rst_rdb", rd_data_b, 0);
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    rst = 1'b1;
    step();
    check_eq("idle_ready", in_ready, 0);
    check_eq("idle_busy", busy, 0);
    in_valid = 1'b0;

    // RGB fill with a gap; a cfg_start during the fill must be ignored.
    start_fill(4'd3, 16'd2, 16'd0);
    for (int i = 1; i <= 3; i++) beat(DATA_W'(i), 1'b0);
    cfg_start = 1'b1; cfg_lanes = 4'd8; cfg_rows = 16'd5; cfg_base = 16'd40;
    gap();
    cfg_start = 1'b0;
    for (int i = 4; i <= 6; i++) beat(DATA_W'(i), 1'b0);
    settle();
    rd_a(16'd0, "rgb_row0");
    check_eq("rgb_row0_const", rd_data_a, 128'h0000_0000_0000_0000_0000_0003_0002_0001);
    rd_a(16'd1, "rgb_row1");
    check_eq("rgb_row1_const", rd_data_a, 128'h0000_0000_0000_0000_0000_0006_0005_0004);

    // Wrap from the last row back to row 0.
    start_fill(4'd8, 16'd2, 16'd79);
    for (int i = 1; i <= 16; i++) beat(DATA_W'(i), 1'b0);
    settle();
    rd_a(16'd79, "wrap_row79");
    check_eq("wrap_row79_const", rd_data_a, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    rd_a(16'd0, "wrap_row0");
    check_eq("wrap_row0_const", rd_data_a, 128'h0010_000F_000E_000D_000C_000B_000A_0009);

    // Port B offset and range limit, then hold with enable low.
    rd_b(16'd54, "portb_row79");
    rd_b(16'd55, "portb_oob");
    rd_addr_b = 16'd54;
    step();
    check_eq("portb_hold", rd_data_b, 0);
    rd_a(16'd200, "porta_oob");

    // Abort on the fifth beat of an 8-lane fill.
    start_fill(4'd8, 16'd1, 16'd10);
    for (int i = 1; i <= 4; i++) beat(DATA_W'(i), 1'b0);
    beat(16'd5, 1'b1);
    settle();
    rd_a(16'd10, "abort_row10");
    check_eq("abort_row10_const", rd_data_a, 128'h0000_0000_0000_0000_0004_0003_0002_0001);

    // Same-cycle read and write of lane 2 of row 5.
    start_fill(4'd3, 16'd1, 16'd5);
    beat(16'h1111, 1'b0);
    beat(16'h2222, 1'b0);
    pre_row = model_row(5);
    rd_en_a = 1'b1; rd_addr_a = 16'd5;
    beat(16'hABCD, 1'b0);
    rd_en_a = 1'b0;
    post_row = model_row(5);
`ifdef WEIGHT_PACK_FWD_EN
    exp_row = post_row;
`else
    exp_row = pre_row;
`endif
    check_eq("collision_read", rd_data_a, exp_row);
    settle();
    rd_a(16'd5, "collision_after");

    // Randomized fills: normalisation, random bases, gaps, aborts, restarts.
    chained = 1'b0;
    for (int it = 0; it < 12; it++) begin
      start_fill(4'($urandom_range(0, 15)), 16'($urandom_range(0, 3)),
                 16'($urandom_range(0, 65535)));
      ab_at = ((it % 4) == 3) ? int'($urandom_range(0, m_total - 1)) : -1;
      for (int k = 0; k < m_total; k++) begin
        if ($urandom_range(0, 3) == 0) gap();
        if (k == ab_at) begin
          beat(16'($urandom), 1'b1);
          break;
        end
        beat(16'($urandom), 1'b0);
      end
      chained = (ab_at < 0) && (it < 11) && ($urandom_range(0, 2) == 0);
      if (!chained) begin
        settle();
        for (int rr = 0; rr < m_rows; rr++) begin
          if (rr * m_lanes < m_count) begin
            row = (m_base + rr) % DEPTH;
            rd_a(16'(row), "rand_rowA");
            if (row >= B_OFFSET) rd_b(16'(row - B_OFFSET), "rand_rowB");
            else rd_b(16'(row + DEPTH - B_OFFSET), "rand_oobB");
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/weight_pack_buffer.md
Name: weight_pack_buffer

Overview:
- Parametrised local weight store for the CNN datapath.
- Packs a serial stream of DATA_W-bit weights into LANES-wide rows and writes them into an internal DEPTH-row dual-read memory.
- Runtime-configurable lanes per row: 3 for RGB layer 1, 8 for the later layers, any value 1..LANES.
- Configurable row count and base row. Two independent registered read ports feed the PE array and the FC stage.

Parameters:
- DATA_W, 16: weight word width.
- LANES, 8: lanes per row; row width is LANES*DATA_W.
- DEPTH, 80: rows of storage.
- B_OFFSET, 25: row offset added to the port-B read address.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cfg_start  input  1  single-cycle pulse; loads the cfg_* inputs and starts a fill.
- cfg_lanes  input  4  lanes per row; 0 is treated as 1; values >LANES are clamped to LANES.
- cfg_rows  input  16  rows to fill; 0 is treated as 1.
- cfg_base  input  16  first row, taken modulo DEPTH.
- abort  input  1  ends the current fill immediately.
- in_valid  input  1  weight beat valid.
- in_data  input  DATA_W  weight word.
- in_ready  output  1  the buffer accepts a beat this cycle.
- busy  output  1  high in FILL.
- done  output  1  one-cycle pulse after the last beat is written.
- fill_row  output  16  current row index relative to base.
- fill_lane  output  4  current lane index.
- rd_en_a  input  1  read enable, port A.
- rd_addr_a  input  16  row address, port A.
- rd_data_a  output  LANES*DATA_W  row data, port A.
- rd_en_b  input  1  read enable, port B.
- rd_addr_b  input  16  row address, port B; B_OFFSET is added internally.
- rd_data_b  output  LANES*DATA_W  row data, port B.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - in_ready, busy, done = 0; fill_row, fill_lane = 0; rd_data_a, rd_data_b = 0.
  - Memory contents are not reset.
- State machine, states IDLE, FILL, DONE:
  - IDLE: cfg_start latches cfg_lanes, cfg_rows, cfg_base (normalised as in Ports), clears row and lane, and moves to FILL.
  - FILL: in_ready = 1, busy = 1.
  - DONE: reached after the last beat; done = 1 for exactly the cycle after the final accepted beat. cfg_start in DONE behaves as in IDLE. With no cfg_start, DONE moves to IDLE on the next cycle.
  - in_ready = 0 in IDLE and DONE.
  - cfg_start during FILL is ignored.
- Beat acceptance: a beat is accepted when in_valid && in_ready. Gaps in in_valid stall the fill with no side effects.
- Write rules, physical row = (cfg_base + fill_row) mod DEPTH:
  - Lane 0 beat: the full row is written as {zeros, in_data}, so lanes not covered by cfg_lanes read back as 0.
  - Lane k>0 beat: only lane k is written, bits [k*DATA_W +: DATA_W]; other lanes are unchanged.
  - Write latency is 1 cycle: the row is visible to a read issued on the next cycle.
- Counters:
  - fill_lane increments per accepted beat.
  - At fill_lane == cfg_lanes-1 it wraps to 0 and fill_row increments.
  - At the last lane of row cfg_rows-1 the state goes to DONE; fill_row and fill_lane return to 0.
- Abort: abort has priority over cfg_start and over a beat in the same cycle.
  - FILL/DONE go to IDLE; the beat in that cycle is not written.
  - done is not pulsed. Rows already written are retained.
- Reads:
  - Registered, 1-cycle latency; reads are independent of the fill state.
  - Port A row = rd_addr_a. Port B row = rd_addr_b + B_OFFSET, computed in 17 bits with no truncation.
  - If the row is >= DEPTH, the registered data is all zeros.
  - When rd_en is low, rd_data holds its previous value.
- Read/write collision (same row, same cycle): the read returns the pre-write contents, unless the optional feature below is enabled.
- Rows past DEPTH-1 wrap to row 0.

Optional Feature:
- Macro: WEIGHT_PACK_FWD_EN.
- Defined: a read colliding with a same-cycle write returns the post-write row. Lane 0 forwards {zeros, in_data}; lane k merges in_data into lane k of the stored row.
- Undefined: read-before-write as specified above. No forwarding logic is built.

Test Plan:
- Reset: hold rst=0 with in_valid=1 → in_ready=0, done=0, rd_data_a=rd_data_b=0. After release the state is IDLE.
- RGB fill: cfg_lanes=3, cfg_rows=2, cfg_base=0, beats 0x0001..0x0006 with one in_valid gap → row0 = 0x0003_0002_0001 and row1 = 0x0006_0005_0004 (upper lanes 0). done pulses once, the cycle after beat 6. in_ready=0 afterwards.
- Wrap: cfg_lanes=8, cfg_rows=2, cfg_base=79, 16 beats → row 79 holds beats 1-8 and row 0 holds beats 9-16. Read rd_addr_a=79 returns beats 8..1 packed, MSB lane = beat 8.
- Port B range: rd_addr_b=54 reads row 79. rd_addr_b=55 → rd_data_b=0. rd_en_b=0 the next cycle → rd_data_b holds 0.
- Abort: abort asserted together with the 5th beat of an 8-lane fill → lanes 0-3 are kept, lane 4 is unwritten, no done pulse, state IDLE.
- Collision: write lane 2 of row 5 = 0xABCD while rd_addr_a=5 → the row shows 0xABCD in lane 2 only with WEIGHT_PACK_FWD_EN defined, and the old value otherwise.
